// File: rtl/pixel_writer_if.sv
// Bundles the line-generator pixel stream and the SRAM write port of pixel_writer.
// slave is the writer's view; master is the view of whatever drives it.
interface pixel_writer_if;
  logic [18:0] pix_addr;
  logic        pix_valid;
  logic        line_done;
  logic [7:0]  color;
  logic        stop;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic        mem_ack;
  logic        write_done;
  logic [7:0]  drop_count;

  modport slave (
    input  pix_addr, pix_valid, line_done, color, mem_ack,
    output stop, mem_addr, mem_wdata, mem_wen, write_done, drop_count
  );

  modport master (
    output pix_addr, pix_valid, line_done, color, mem_ack,
    input  stop, mem_addr, mem_wdata, mem_wen, write_done, drop_count
  );
endinterface

// File: rtl/pixel_writer.sv
// Buffers line-generator pixels in a FIFO and drains them to SRAM with req/ack writes,
// throttling the generator with stop and flagging when a finished line is fully committed.
module pixel_writer #(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2,
  parameter int MAX_ADDR     = 307199
) (
  input  logic          clk,
  input  logic          rst,
  pixel_writer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  color;
  } pix_entry_t;

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t        r_state, w_state_nxt;
  pix_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_stop, r_pending;
  logic [18:0]   r_addr;
  logic [7:0]    r_wdata, r_drop;
  logic          w_in_range, w_full, w_empty, w_load, w_push, w_drop, w_done;

  assign w_in_range  = bus.pix_addr <= 19'(MAX_ADDR);
  assign w_full      = r_count == CW'(DEPTH);
  assign w_empty     = r_count == '0;
  // A pop on the same edge frees a slot, so a full FIFO can still take a pixel.
  assign w_push      = bus.pix_valid && w_in_range && (!w_full || w_load);
  assign w_drop      = bus.pix_valid && !w_push;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_load);
  assign w_done      = r_pending && w_empty && (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          if (!w_empty) w_load      = 1'b1;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{addr: bus.pix_addr, color: bus.color};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_stop    <= 1'b0;
      r_pending <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_drop    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_load) begin
        r_addr  <= r_mem[r_rptr].addr;
        r_wdata <= r_mem[r_rptr].color;
        r_rptr  <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_stop  <= w_count_nxt >= CW'(DEPTH - AFULL_MARGIN);
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      // line_done arriving on the completion edge is folded into the line just reported.
      r_pending <= w_done ? 1'b0 : (r_pending || bus.line_done);
    end
  end

  assign bus.stop       = r_stop;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.mem_wen    = (r_state == S_WRITE);
  assign bus.write_done = w_done;
  assign bus.drop_count = r_drop;
endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: directed vector table, hand sequences for
// stall/full corners, then random traffic against a queue-based reference model.
module tb_pixel_writer;
  localparam int DEPTH  = 8;
  localparam int MARGIN = 2;
  localparam int MAXA   = 307199;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_writer_if bus();

  pixel_writer #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN), .MAX_ADDR(MAXA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference model: FIFO contents, in-flight write, pending line flag
  logic [26:0] mq[$];
  logic [26:0] m_cur;
  bit          m_busy, m_pend, m_stop;
  int          m_drop;
  logic [18:0] wlog[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic model_step(input logic r, pv, input logic [18:0] a, input logic [7:0] c,
                            input logic ld, ack);
    int sz;
    bit take, fire, acc;
    if (r) begin
      mq.delete();
      m_busy = 0; m_pend = 0; m_stop = 0; m_drop = 0;
      return;
    end
    sz   = mq.size();
    take = (sz > 0) && (!m_busy || ack);
    fire = m_pend && sz == 0 && !m_busy;
    acc  = pv && (int'(a) <= MAXA) && (sz < DEPTH || take);
    if (take) m_cur = mq.pop_front();
    if (m_busy && ack && sz == 0) m_busy = 0;
    else if (take)                m_busy = 1;
    if (acc) mq.push_back({a, c});
    if (pv && !acc && m_drop < 255) m_drop++;
    m_pend = fire ? 1'b0 : (m_pend | ld);
    m_stop = mq.size() >= DEPTH - MARGIN;
  endtask

  task automatic tick(input logic r, pv, input logic [18:0] a, input logic [7:0] c,
                      input logic ld, ack);
    bit hs;
    logic [18:0] ha;
    rst = r; bus.pix_valid = pv; bus.pix_addr = a; bus.color = c;
    bus.line_done = ld; bus.mem_ack = ack;
    hs = (bus.mem_wen === 1'b1) && ack && !r;
    ha = bus.mem_addr;
    @(posedge clk);
    if (hs) wlog.push_back(ha);
    model_step(r, pv, a, c, ld, ack);
    #1;
    chk("m_stop", bus.stop, m_stop);
    chk("m_wen",  bus.mem_wen, m_busy);
    chk("m_done", bus.write_done, m_pend && mq.size() == 0 && !m_busy);
    chk("m_drop", bus.drop_count, m_drop);
    if (m_busy) begin
      chk("m_addr",  bus.mem_addr,  m_cur[26:8]);
      chk("m_wdata", bus.mem_wdata, m_cur[7:0]);
    end
  endtask

  typedef struct {
    logic rst, pv; logic [18:0] addr; logic [7:0] col; logic ld, ack;
    logic e_stop, e_wen; logic [18:0] e_addr; logic [7:0] e_wd; logic e_done; logic [7:0] e_drop;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, pv, logic [18:0] a, logic [7:0] c, logic ld, ack,
                              logic es, ew, logic [18:0] ea, logic [7:0] ed, logic edn,
                              logic [7:0] edr);
    vec_t v;
    v = '{r, pv, a, c, ld, ack, es, ew, ea, ed, edn, edr};
    return v;
  endfunction

  initial begin
    int nxt, first_stop;
    bus.pix_valid = 0; bus.pix_addr = '0; bus.color = '0; bus.line_done = 0; bus.mem_ack = 0;

    //               rst pv addr    col    ld ack | stop wen addr    wd     done drop
    tbl.push_back(mk(1, 0, 19'd0,   8'h00, 0, 0,   0,   0,  19'd0,   8'h00, 0,   8'd0)); // reset
    tbl.push_back(mk(0, 1, 19'h4B0, 8'h3C, 0, 1,   0,   0,  19'd0,   8'h00, 0,   8'd0)); // single pixel
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 1, 1,   0,   1,  19'h4B0, 8'h3C, 0,   8'd0));
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 0, 1,   0,   0,  19'd0,   8'h00, 1,   8'd0));
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 0, 1,   0,   0,  19'd0,   8'h00, 0,   8'd0));
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 1, 0,   0,   0,  19'd0,   8'h00, 1,   8'd0)); // empty line
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 1, 0,   0,   0,  19'd0,   8'h00, 0,   8'd0)); // 2nd pulse merged
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 0, 0,   0,   0,  19'd0,   8'h00, 0,   8'd0));
    tbl.push_back(mk(0, 1, 19'd307199, 8'h11, 0, 1, 0,  0,  19'd0,   8'h00, 0,   8'd0)); // range
    tbl.push_back(mk(0, 1, 19'd307200, 8'h22, 0, 1, 0,  1,  19'd307199, 8'h11, 0, 8'd1));
    tbl.push_back(mk(0, 1, 19'd524287, 8'h33, 0, 1, 0,  0,  19'd0,   8'h00, 0,   8'd2));
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 0, 1,   0,   0,  19'd0,   8'h00, 0,   8'd2));
    tbl.push_back(mk(0, 1, 19'd5,   8'hAA, 0, 0,   0,   0,  19'd0,   8'h00, 0,   8'd2)); // reset mid-write
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 0, 0,   0,   1,  19'd5,   8'hAA, 0,   8'd2));
    tbl.push_back(mk(1, 0, 19'd0,   8'h00, 0, 1,   0,   0,  19'd0,   8'h00, 0,   8'd0));
    tbl.push_back(mk(0, 1, 19'd6,   8'h55, 0, 0,   0,   0,  19'd0,   8'h00, 0,   8'd0));
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 0, 0,   0,   1,  19'd6,   8'h55, 0,   8'd0));
    tbl.push_back(mk(0, 0, 19'd0,   8'h00, 0, 1,   0,   0,  19'd0,   8'h00, 0,   8'd0));

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].pv, tbl[i].addr, tbl[i].col, tbl[i].ld, tbl[i].ack);
      chk($sformatf("v%0d_stop", i), bus.stop, tbl[i].e_stop);
      chk($sformatf("v%0d_wen", i),  bus.mem_wen, tbl[i].e_wen);
      chk($sformatf("v%0d_done", i), bus.write_done, tbl[i].e_done);
      chk($sformatf("v%0d_drop", i), bus.drop_count, tbl[i].e_drop);
      if (tbl[i].e_wen || tbl[i].rst) begin
        chk($sformatf("v%0d_addr", i), bus.mem_addr, tbl[i].e_addr);
        chk($sformatf("v%0d_wd", i),   bus.mem_wdata, tbl[i].e_wd);
      end
    end

    // burst 100..109 against a stalled SRAM, generator honouring stop
    tick(1, 0, 0, 0, 0, 0);
    wlog.delete();
    nxt = 100; first_stop = -1;
    for (int cyc = 0; cyc < 200 && wlog.size() < 10; cyc++) begin
      logic pv;
      pv = (nxt <= 109) && !bus.stop;
      tick(0, pv, 19'(nxt), 8'(nxt), 0, cyc >= 12);
      if (pv) nxt++;
      if (first_stop < 0 && bus.stop) first_stop = nxt;
    end
    chk("burst_stop_after_107", first_stop, 107);
    chk("burst_nwrites", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) chk("burst_order", wlog[i], 100 + i);
    chk("burst_drop", bus.drop_count, 0);

    // fill to full, then push+pop on the same edge, then a true overflow
    tick(1, 0, 0, 0, 0, 0);
    wlog.delete();
    for (int i = 0; i < 9; i++) tick(0, 1, 19'(200 + i), 8'(i), 0, 0);
    chk("full_stop", bus.stop, 1);
    tick(0, 1, 19'd209, 8'd9, 0, 1);
    chk("full_pushpop_drop", bus.drop_count, 0);
    tick(0, 1, 19'd210, 8'd10, 0, 0);
    chk("full_overflow_drop", bus.drop_count, 1);
    for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, 0, 1);
    chk("full_nwrites", wlog.size(), 10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) chk("full_order", wlog[i], 200 + i);

    // random traffic
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      logic pv, r;
      logic [18:0] a;
      r  = ($urandom_range(0, 499) == 0);
      pv = ($urandom_range(0, 99) < 60) && (!bus.stop || $urandom_range(0, 99) < 5);
      a  = ($urandom_range(0, 9) == 0) ? 19'($urandom_range(307200, 524287))
                                       : 19'($urandom_range(0, 307199));
      tick(r, pv, a, 8'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, checks so far %0d", n_chk);
    $fatal(1);
  end
endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Sits directly downstream of the Bresenham line generator, on the path to the frame-buffer SRAM.
- Accepts the generator's stream of 19-bit linear pixel addresses (640x480, address = y*640 + x) and buffers them in a small FIFO.
- Drains the FIFO to SRAM over a request/acknowledge write interface.
- Throttles the generator through its stop input and reports when a line has been fully committed to memory.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 4 to 32.
- AFULL_MARGIN, 2, free entries remaining at which stop asserts.
- MAX_ADDR, 307199, highest legal pixel address; larger addresses are dropped.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- pix_addr  in  19  pixel address from the line generator.
- pix_valid  in  1  pix_addr valid this cycle.
- line_done  in  1  one-cycle pulse: generator has emitted the last pixel of the line.
- color  in  8  draw colour, sampled together with each accepted pixel.
- stop  out  1  to the line generator: hold, do not emit new pixels.
- mem_addr  out  19  SRAM write address.
- mem_wdata  out  8  SRAM write data.
- mem_wen  out  1  write request; held until acknowledged.
- mem_ack  in  1  SRAM accepted the current write this cycle.
- write_done  out  1  one-cycle pulse: every pixel of the finished line is in SRAM.
- drop_count  out  8  saturating count of out-of-range addresses dropped.

Behaviour:
- Reset (rst high at a clk edge, overrides all other inputs):
  - FIFO emptied, state IDLE, pending-done flag cleared.
  - stop=0, mem_wen=0, mem_addr=0, mem_wdata=0, write_done=0, drop_count=0.
  - Reset during an outstanding write abandons it; mem_wen drops the next cycle regardless of mem_ack.
- Input acceptance:
  - A pixel is accepted on any edge where pix_valid=1, pix_addr<=MAX_ADDR and the FIFO is not full.
  - Each accepted entry stores {pix_addr, color}.
  - pix_valid=1 with pix_addr>MAX_ADDR: entry discarded; drop_count increments, saturating at 255.
  - pix_valid=1 while the FIFO is full is an overflow: pixel discarded, drop_count increments. The stop margin makes this unreachable for a compliant generator.
- Backpressure:
  - stop is registered: stop=1 when occupancy >= DEPTH-AFULL_MARGIN, computed after the current edge's push/pop.
  - The margin absorbs one cycle of generator latency.
- Occupancy:
  - Count is 0..DEPTH, with width clog2(DEPTH)+1.
  - Read and write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves the count unchanged, including when the FIFO is full (pop frees a slot the same edge) and when it is empty (push then pop on later edges only; no bypass).
- Write state machine:
  - IDLE: when the FIFO is non-empty, load the head entry into mem_addr/mem_wdata, set mem_wen=1, go to WRITE. First write request appears 1 cycle after the first push.
  - WRITE: hold mem_wen, mem_addr and mem_wdata stable until mem_ack=1.
    - On ack with the FIFO still non-empty after the pop: load the next entry and stay in WRITE, giving back-to-back writes with no idle cycle.
    - On ack with the FIFO empty: go to IDLE with mem_wen=0.
  - mem_ack while mem_wen=0 is ignored.
- Line completion:
  - line_done sets the pending flag.
  - write_done pulses for exactly 1 cycle on the first edge where pending=1, the FIFO is empty and no write is outstanding (state IDLE); the flag then clears.
  - If the line was empty or fully dropped, write_done pulses on the cycle after line_done.
  - A second line_done while pending yields a single write_done.
  - A pixel accepted in the same cycle as line_done belongs to that line.
- Ordering: SRAM writes occur in exact acceptance order. No coalescing and no reordering.

Test Plan:
- Single pixel: reset, push addr=0x04B0 color=0x3C, mem_ack tied 1 -> mem_wen=1 with mem_addr=0x04B0, mem_wdata=0x3C one cycle after push; line_done then gives write_done two cycles later.
- Burst with stall: push 10 consecutive addrs 100..109, DEPTH=8, mem_ack=0 for 12 cycles then 1 -> stop rises when count reaches 6; 10 writes then appear in order 100..109; drop_count=0.
- Range check: push 307199, 307200, 524287 -> only 307199 written; drop_count=2.
- Simultaneous push/pop at full: FIFO full, mem_ack=1 and pix_valid=1 on the same edge -> count stays 8; pixel accepted; no drop.
- Empty line: line_done with no pixels -> write_done on the next cycle; a second line_done pulse during that wait -> still one write_done.
- Reset mid-write: mem_wen=1 awaiting ack, rst=1 for one edge -> all outputs at reset values next cycle; subsequent pushes resume normal operation from an empty FIFO.
